// File: rtl/ddr3_tg_pkg.sv
// Shared constants, state encoding and data-pattern function for the DDR3 traffic checker.
package ddr3_tg_pkg;

   localparam logic [2:0]  CMD_WR       = 3'b000;
   localparam logic [2:0]  CMD_RD       = 3'b001;
   localparam logic [31:0] PATTERN_SEED = 32'h5A3C_96E1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_RD_WAIT
   } state_e;

   // One 32-bit word of a beat: pass tag, word lane and beat index, scrambled by the seed.
   function automatic logic [31:0] pattern_word(input logic [7:0]  pass,
                                                input logic [1:0]  k,
                                                input logic [21:0] i);
      return {pass, k, i} ^ PATTERN_SEED;
   endfunction

endpackage

// File: rtl/ddr3_tg_pattern.sv
// Maps (beat index, pass) to a full user-data beat; used both to generate writes and to expect reads.
module ddr3_tg_pattern
   import ddr3_tg_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int IDX_W      = 9
) (
   input  logic [IDX_W-1:0]      idx,
   input  logic [7:0]            pass,
   output logic [DATA_WIDTH-1:0] beat
);

   localparam int WORDS = DATA_WIDTH / 32;

   always_comb begin
      beat = '0;
      for (int k = 0; k < WORDS; k++) begin
         beat[32*k +: 32] = pattern_word(pass, k[1:0], 22'(idx));
      end
   end

endmodule

// File: rtl/ddr3_traffic_checker.sv
// Self-test traffic source/sink for the DDR3 MC user port: write NUM_CMDS beats, read them back, compare, repeat.
module ddr3_traffic_checker
   import ddr3_tg_pkg::*;
#(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128,
   parameter int NUM_CMDS   = 256,
   parameter int ADDR_STEP  = 8,
   parameter int BASE_ADDR  = 0,
   parameter int TIMEOUT    = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_calib_complete,
   input  logic                    cmd_ready,
   output logic [2:0]              cmd,
   output logic                    cmd_en,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [5:0]              app_burst_number,
   input  logic                    wr_data_rdy,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_data_en,
   output logic                    wr_data_end,
   output logic [DATA_WIDTH/8-1:0] wr_data_mask,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    rd_data_valid,
   output logic                    error,
   output logic                    error1,
   output logic [15:0]             pass_cnt
);

   localparam int               IDX_W    = $clog2(NUM_CMDS) + 1;
   localparam int               WD_W     = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);
   localparam logic [IDX_W-1:0] ALL_IDX  = IDX_W'(NUM_CMDS);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
   logic [IDX_W-1:0]      outst_q, outst_d;
   logic [WD_W-1:0]       wdog_q, wdog_d;
   logic [15:0]           pass_q, pass_d;
   logic                  calib_q, calib_d;
   logic                  error_q, error_d;
   logic                  error1_q, error1_d;
   logic                  wr_xfer, rd_accept, beat_ok, abort, in_rd_phase;
   logic [DATA_WIDTH-1:0] wr_beat, exp_beat;
   logic [ADDR_WIDTH-1:0] burst_addr;

   assign burst_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STEP);

   ddr3_tg_pattern #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_wr_pattern (
      .idx  (idx_q),
      .pass (pass_q[7:0]),
      .beat (wr_beat)
   );

   ddr3_tg_pattern #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_rd_expect (
      .idx  (rx_idx_q),
      .pass (pass_q[7:0]),
      .beat (exp_beat)
   );

   always_comb begin
      // NOTE: every output and every _d gets a default first, so no path through the case can infer a latch.
      state_d    = state_q;
      idx_d      = idx_q;
      rx_idx_d   = rx_idx_q;
      outst_d    = outst_q;
      wdog_d     = wdog_q;
      pass_d     = pass_q;
      calib_d    = init_calib_complete;
      error_d    = error_q;
      error1_d   = error1_q;
      cmd        = CMD_WR;
      cmd_en     = 1'b0;
      wr_data_en = 1'b0;
      addr       = '0;
      wr_data    = '0;
      wr_xfer    = 1'b0;
      rd_accept  = 1'b0;
      beat_ok    = 1'b0;

      in_rd_phase = (state_q == ST_READ) || (state_q == ST_RD_WAIT);
      // Loss of calibration or a stalled watchdog kills the pass before any strobe is issued this cycle.
      abort = (state_q != ST_IDLE) && (!calib_q || (wdog_q == WD_LIMIT));

      if (!abort) begin
         unique case (state_q)
            ST_IDLE: begin
               if (calib_q) state_d = ST_WRITE;
            end
            ST_WRITE: begin
               addr    = burst_addr;
               wr_data = wr_beat;
               if (cmd_ready && wr_data_rdy) begin
                  cmd_en     = 1'b1;
                  wr_data_en = 1'b1;
                  wr_xfer    = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_READ;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            ST_READ: begin
               addr = burst_addr;
               cmd  = CMD_RD;
               if (cmd_ready) begin
                  cmd_en    = 1'b1;
                  rd_accept = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_RD_WAIT;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      if (rd_data_valid) begin
         if (in_rd_phase && (outst_q != '0)) begin
            beat_ok  = 1'b1;
            rx_idx_d = rx_idx_q + 1'b1;
            if (rd_data != exp_beat) error_d = 1'b1;
         end else begin
            error1_d = 1'b1;
         end
      end

      case ({rd_accept, beat_ok})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: ;
      endcase

      if ((state_q == ST_RD_WAIT) && (rx_idx_d == ALL_IDX)) begin
         state_d  = ST_WRITE;
         pass_d   = pass_q + 1'b1;
         rx_idx_d = '0;
         outst_d  = '0;
      end

      if ((state_q == ST_IDLE) || wr_xfer || rd_accept || rd_data_valid) wdog_d = '0;
      else                                                                 wdog_d = wdog_q + 1'b1;

      if (abort) begin
         state_d  = ST_IDLE;
         idx_d    = '0;
         rx_idx_d = '0;
         outst_d  = '0;
         wdog_d   = '0;
         pass_d   = pass_q;
         if (wdog_q == WD_LIMIT) error1_d = 1'b1;
      end
   end

   // NOTE: registers take non-blocking assignments only; all next-state math lives in the always_comb above.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         rx_idx_q <= '0;
         outst_q  <= '0;
         wdog_q   <= '0;
         pass_q   <= '0;
         calib_q  <= 1'b0;
         error_q  <= 1'b0;
         error1_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rx_idx_q <= rx_idx_d;
         outst_q  <= outst_d;
         wdog_q   <= wdog_d;
         pass_q   <= pass_d;
         calib_q  <= calib_d;
         error_q  <= error_d;
         error1_q <= error1_d;
      end
   end

   assign app_burst_number = '0;
   assign wr_data_mask     = '0;
   assign wr_data_end      = wr_data_en;
   assign error            = error_q;
   assign error1           = error1_q;
   assign pass_cnt         = pass_q;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Scoreboard bench for ddr3_traffic_checker with a behavioural MC model (random ready, variable read latency).
`timescale 1ns/1ps
module tb_ddr3_traffic_checker;

   localparam int          AW   = 28;
   localparam int          DW   = 128;
   localparam int          NC   = 4;
   localparam int          STEP = 8;
   localparam int          TMO  = 100;
   localparam logic [31:0] SEED = 32'h5A3C_96E1;

   logic           clk = 1'b0;
   logic           rst;
   logic           calib;
   logic           cmd_ready, wr_data_rdy, rd_data_valid;
   logic [2:0]     cmd;
   logic           cmd_en, wr_data_en, wr_data_end, error, error1;
   logic [AW-1:0]  addr;
   logic [5:0]     app_burst_number;
   logic [DW-1:0]  wr_data, rd_data;
   logic [DW/8-1:0] wr_data_mask;
   logic [15:0]    pass_cnt;

   always #5 clk = ~clk;

   ddr3_traffic_checker #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CMDS(NC),
      .ADDR_STEP(STEP), .BASE_ADDR(0), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .init_calib_complete(calib),
      .cmd_ready(cmd_ready), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
      .app_burst_number(app_burst_number), .wr_data_rdy(wr_data_rdy),
      .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_data_end(wr_data_end),
      .wr_data_mask(wr_data_mask), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .error(error), .error1(error1), .pass_cnt(pass_cnt)
   );

   typedef struct {
      logic [2:0]    cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } rd_t;

   exp_t          exp_q[$];
   rd_t           rq[$];
   logic [DW-1:0] mem [int];

   int checks = 0, failures = 0;
   int cyc = 0, cmd_seen = 0, fed_upto = 0;
   bit feed_en = 0, rand_mode = 0, hold = 0, flip_en = 0, flip_sent = 0, spur_req = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat_of(input int i, input int p);
      logic [DW-1:0] b;
      for (int k = 0; k < 4; k++) b[32*k +: 32] = {p[7:0], k[1:0], i[21:0]} ^ SEED;
      return b;
   endfunction

   task automatic push_pass(input int p);
      for (int i = 0; i < NC; i++) exp_q.push_back('{3'b000, AW'(i*STEP), beat_of(i, p)});
      for (int i = 0; i < NC; i++) exp_q.push_back('{3'b001, AW'(i*STEP), '0});
   endtask

   task automatic sb_restart(input int p);
      exp_q.delete();
      push_pass(p);
      fed_upto = p;
   endtask

   // Keep the expectation queue one pass ahead of the running pass.
   always @(negedge clk) begin
      if (feed_en && (fed_upto < int'(pass_cnt) + 1)) begin
         fed_upto++;
         push_pass(fed_upto);
      end
   end

   // Monitor: every strobe pops the scoreboard and also feeds the MC model.
   always @(negedge clk) begin : mon
      exp_t e;
      if (cmd_en) begin
         cmd_seen++;
         check("strobe_cmd_ready", cmd_ready, 1'b1);
         check("burst_number", app_burst_number, 0);
         check("wr_mask", wr_data_mask, 0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_cmd actual=cmd %0d addr %0h required=no command", cmd, addr);
         end else begin
            e = exp_q.pop_front();
            check("sb_cmd", cmd, e.cmd);
            check("sb_addr", addr, e.addr);
            check("sb_wr_en", wr_data_en, e.cmd == 3'b000);
            if (e.cmd == 3'b000) begin
               check("sb_wr_data", wr_data, e.data);
               check("sb_wr_rdy", wr_data_rdy, 1'b1);
               check("sb_wr_end", wr_data_end, 1'b1);
            end
         end
         if (cmd == 3'b000) mem[int'(addr)] = wr_data;
         else rq.push_back('{addr, cyc + (rand_mode ? int'($urandom_range(1, 6)) : 2)});
      end
   end

   // MC model driver: ready lines and in-order read returns, updated just after each rising edge.
   initial begin : mc
      rd_t r;
      cmd_ready = 1'b0; wr_data_rdy = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (hold) begin
            cmd_ready = 1'b0; wr_data_rdy = 1'b0;
         end else if (rand_mode) begin
            cmd_ready = 1'($urandom_range(0, 1)); wr_data_rdy = 1'($urandom_range(0, 1));
         end else begin
            cmd_ready = 1'b1; wr_data_rdy = 1'b1;
         end
         rd_data_valid = 1'b0;
         rd_data       = '0;
         if (spur_req) begin
            rd_data_valid = 1'b1;
            spur_req      = 0;
         end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            rd_data = mem.exists(int'(r.addr)) ? mem[int'(r.addr)] : '0;
            if (flip_en && r.addr == AW'(16)) begin
               rd_data[5] = ~rd_data[5];
               flip_en    = 0;
               flip_sent  = 1;
            end
            rd_data_valid = 1'b1;
         end
      end
   end

   task automatic wait_pass(input int target, input int budget);
      int n = 0;
      while (int'(pass_cnt) != target && n < budget) begin @(negedge clk); n++; end
      check("wait_pass", pass_cnt, target);
   endtask

   task automatic wait_cmd(input logic [2:0] c, input int a, input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(cmd_en && cmd == c && (a < 0 || int'(addr) == a)) && n < budget);
      check(name, {cmd_en, cmd}, {1'b1, c});
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cmd_en"}, cmd_en, 0);
      check({tag, "_wr_en"}, wr_data_en, 0);
      check({tag, "_wr_end"}, wr_data_end, 0);
      check({tag, "_cmd"}, cmd, 0);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_error1"}, error1, 0);
      check({tag, "_pass_cnt"}, pass_cnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin : main
      int n, p;
      rst = 1'b1;
      calib = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;

      // Calibration held low: no traffic.
      repeat (1000) @(negedge clk);
      check("calib_low_no_cmd", cmd_seen, 0);

      // Clean pass with ready always high.
      sb_restart(0);
      feed_en = 1;
      calib   = 1'b1;
      wait_cmd(3'b000, 0, 20, "first_wr");
      check("first_wr_addr", addr, 0);
      check("first_wr_word0", wr_data[31:0], 32'h5A3C_96E1);
      check("first_wr_word1", wr_data[63:32], 32'h5A7C_96E1);
      wait_pass(1, 100);
      check("clean_error", error, 0);
      check("clean_error1", error1, 0);

      // Single-bit corruption of beat 2 readback.
      flip_en = 1;
      n = 0;
      while (!flip_sent && n < 200) begin @(negedge clk); n++; end
      check("flip_seen", flip_sent, 1'b1);
      check("flip_error_before", error, 0);
      @(negedge clk);
      check("flip_error_after", error, 1);
      check("flip_error1", error1, 0);
      wait_pass(3, 200);
      check("flip_error_sticky", error, 1);

      // Random back-pressure on both ready lines.
      rand_mode = 1;
      wait_pass(5, 3000);
      rand_mode = 0;
      check("rand_error1", error1, 0);

      // Watchdog: stall after two writes of the current pass.
      wait_cmd(3'b000, 8, 200, "tmo_pre_wr");
      hold = 1;
      p = int'(pass_cnt);
      check("tmo_error1_start", error1, 0);
      repeat (50) @(negedge clk);
      check("tmo_error1_early", error1, 0);
      sb_restart(p);
      repeat (60) @(negedge clk);
      check("tmo_error1", error1, 1);
      check("tmo_error_kept", error, 1);
      hold = 0;
      wait_cmd(3'b000, -1, 20, "tmo_restart_wr");
      check("tmo_restart_addr", addr, 0);
      check("tmo_restart_pass", pass_cnt, p);

      // Reset asserted during a read phase.
      wait_cmd(3'b001, -1, 200, "rst_pre_rd");
      #1 rst = 1'b1;
      feed_en = 0;
      flip_en = 0;
      rq.delete();
      #1 check_idle("rst_mid");
      calib = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sb_restart(0);
      feed_en = 1;
      repeat (5) @(negedge clk);
      calib = 1'b1;
      wait_cmd(3'b000, -1, 20, "rst_restart_wr");
      check("rst_restart_addr", addr, 0);
      check("rst_restart_word0", wr_data[31:0], 32'h5A3C_96E1);
      wait_pass(1, 200);

      // Spurious read beat during a write phase.
      wait_cmd(3'b000, 0, 100, "spur_pre_wr");
      spur_req = 1;
      @(negedge clk);
      check("spur_error1_pre", error1, 0);
      @(negedge clk);
      check("spur_error1", error1, 1);
      check("spur_error_unchanged", error, 0);
      p = int'(pass_cnt);
      wait_pass(p + 1, 200);
      check("final_error", error, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
